// File: rtl/operand_capture_pkg.sv
// Shared types for the operand capture stage.
//   STATE_W : width of the encoded FSM state (drives the board LEDs)
//   state_t : WAIT_A / WAIT_B / SHOW with fixed encodings; 2'd3 is unused
package operand_capture_pkg;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      SHOW   = 2'd2
   } state_t;
endpackage

// File: rtl/operand_capture_fsm_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle pulse on every accepted 0->1 transition.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   btn_raw : raw, bouncy, asynchronous button (active high)
//   press   : registered 1-cycle pulse per accepted press
// A raw rise held steady produces press DEBOUNCE_CYCLES+2 cycles later.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);
   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_press;

   // The counter measures how long the synced button has disagreed with the
   // accepted level; any cycle of agreement (a bounce back) restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_press <= r_sync2;   // pulse only on release->pressed
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign press = r_press;
endmodule

// File: rtl/operand_capture_fsm.sv
// Operand entry for the 3-bit magnitude comparator: press 1 loads A from the
// switches, press 2 loads B and raises vals_valid, press 3 returns to A entry.
//   clk, rst_n   : clock / asynchronous active-low reset
//   sw           : raw switches (asynchronous), synchronized before use
//   btn_load     : raw load button, debounced in btn_debounce
//   valA, valB   : captured operands, held until overwritten
//   vals_valid   : 1 while in SHOW
//   state_o      : encoded FSM state
// Optional macro OPERAND_CAPTURE_TIMEOUT_EN: leave SHOW after TIMEOUT_CYCLES
// cycles without a press.
module operand_capture_fsm
   import operand_capture_pkg::*;
#(
   parameter int WIDTH           = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   sw,
   input  logic               btn_load,
   output logic [WIDTH-1:0]   valA,
   output logic [WIDTH-1:0]   valB,
   output logic               vals_valid,
   output logic [STATE_W-1:0] state_o
);
   logic [WIDTH-1:0] r_sw1;
   logic [WIDTH-1:0] r_sw2;
   logic [WIDTH-1:0] r_valA;
   logic [WIDTH-1:0] r_valB;
   logic             r_valid;
   state_t           r_state;
   state_t           w_next;
   logic             w_press;
   logic             w_capA;
   logic             w_capB;
   logic             w_timeout;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_load),
      .press   (w_press)
   );

`ifdef OPERAND_CAPTURE_TIMEOUT_EN
   localparam int            DW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DW-1:0] DW_MAX = DW'(TIMEOUT_CYCLES - 1);
   logic [DW-1:0] r_dwell;

   // Zero on the SHOW entry edge (state was WAIT_B), then counts SHOW cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_dwell <= '0;
      else if (r_state != SHOW) r_dwell <= '0;
      else                     r_dwell <= r_dwell + 1'b1;
   end

   assign w_timeout = (r_state == SHOW) && (r_dwell == DW_MAX);
`else
   // Parameter kept so both builds share one interface.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
   end
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      w_capA = 1'b0;
      w_capB = 1'b0;
      case (r_state)
         WAIT_A: if (w_press) begin w_next = WAIT_B; w_capA = 1'b1; end
         WAIT_B: if (w_press) begin w_next = SHOW;   w_capB = 1'b1; end
         SHOW:   if (w_press || w_timeout) w_next = WAIT_A;
         default: w_next = WAIT_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw1   <= '0;
         r_sw2   <= '0;
         r_state <= WAIT_A;
         r_valid <= 1'b0;
         r_valA  <= '0;
         r_valB  <= '0;
      end else begin
         r_sw1   <= sw;
         r_sw2   <= r_sw1;
         r_state <= w_next;
         r_valid <= (w_next == SHOW);   // tracks r_state on the same edge
         if (w_capA) r_valA <= r_sw2;
         if (w_capB) r_valB <= r_sw2;
      end
   end

   assign valA       = r_valA;
   assign valB       = r_valB;
   assign vals_valid = r_valid;
   assign state_o    = r_state;
endmodule

// File: tb/tb_operand_capture_fsm.sv
module tb_operand_capture_fsm;
   localparam int W   = 3;
   localparam int DEB = 4;
   localparam int TO  = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] sw = '0;
   logic         btn = 1'b0;
   logic [W-1:0] valA, valB;
   logic         vals_valid;
   logic [1:0]   state_o;

   int errors = 0;
   int checks = 0;
   int npress = 0;

   operand_capture_fsm #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn),
      .valA(valA), .valB(valB), .vals_valid(vals_valid), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference: a level is accepted once the last DEB synchronized samples
   // (raw delayed by two clocks) all disagree with the current level; a rise
   // emits one pulse; the entry sequencer reacts to the pulse one clock later.
   logic [DEB:0] hist;
   logic         m_level, m_press;
   logic [1:0]   m_state;
   logic [W-1:0] m_a, m_b, sw_h0, sw_h1;
   int           cyc, m_entry;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= '0; m_level <= 1'b0; m_press <= 1'b0; m_state <= 2'd0;
         m_a <= '0; m_b <= '0; sw_h0 <= '0; sw_h1 <= '0; cyc <= 0; m_entry <= 0;
      end else begin
         cyc   <= cyc + 1;
         hist  <= {hist[DEB-1:0], btn};
         sw_h0 <= sw;
         sw_h1 <= sw_h0;
         if (hist[DEB:1] == {DEB{~m_level}}) begin
            m_level <= ~m_level;
            m_press <= ~m_level;
         end else begin
            m_press <= 1'b0;
         end
         if (m_press) begin
            case (m_state)
               2'd0:    begin m_a <= sw_h1; m_state <= 2'd1; end
               2'd1:    begin m_b <= sw_h1; m_state <= 2'd2; m_entry <= cyc; end
               default: m_state <= 2'd0;
            endcase
         end
`ifdef OPERAND_CAPTURE_TIMEOUT_EN
         else if (m_state == 2'd2 && cyc - m_entry == TO) m_state <= 2'd0;
`endif
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_press", dut.u_deb.press, m_press);
         chk("m_state", state_o, m_state);
         chk("m_valid", vals_valid, m_state == 2'd2);
         chk("m_valA", valA, m_a);
         chk("m_valB", valB, m_b);
         if (dut.u_deb.press === 1'b1) npress++;
      end
   end

   task automatic wait_press(input string tag);
      int n = 0;
      repeat (20) begin
         @(posedge clk); #1;
         n++;
         if (dut.u_deb.press === 1'b1) break;
      end
      chk({tag, "_lat"}, n, DEB + 2);
   endtask

   // Settle, raise the button, measure latency, release; returns just after
   // the FSM edge that consumed the pulse.
   task automatic do_press(input logic [W-1:0] v, input string tag);
      sw = v;
      tick(8);
      btn = 1'b1;
      wait_press(tag);
      @(negedge clk); btn = 1'b0;
      @(negedge clk);
   endtask

   int p0, st0;

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(2);
      chk("rst_state", state_o, 0);
      chk("rst_valid", vals_valid, 0);
      chk("rst_valA", valA, 0);

      // normal entry
      do_press(3'd5, "entA");
      chk("entA_state", state_o, 1);
      chk("entA_valA", valA, 5);
      do_press(3'd2, "entB");
      chk("entB_valA", valA, 5);
      chk("entB_valB", valB, 2);
      chk("entB_valid", vals_valid, 1);
      chk("entB_state", state_o, 2);

      // wrap back to A entry (the dwell limit does it when enabled)
`ifdef OPERAND_CAPTURE_TIMEOUT_EN
      tick(10);
`else
      do_press(3'd3, "wrap");
`endif
      chk("wrap_state", state_o, 0);
      chk("wrap_valid", vals_valid, 0);
      chk("wrap_valA", valA, 5);
      chk("wrap_valB", valB, 2);
      do_press(3'd7, "reA");
      chk("reA_valA", valA, 7);
      chk("reA_state", state_o, 1);

      // 3-cycle glitch alone: no press
      tick(8);
      p0 = npress; st0 = state_o;
      btn = 1'b1; tick(3); btn = 1'b0; tick(10);
      chk("glitch_press", npress - p0, 0);
      chk("glitch_state", state_o, st0);

      // bounce then hold: exactly one press, release adds none
      sw = 3'd1; tick(3);
      p0 = npress;
      btn = 1'b1; tick(1); btn = 1'b0; tick(1);
      btn = 1'b1; tick(1); btn = 1'b0; tick(1);
      btn = 1'b1; tick(10);
      chk("bounce_press", npress - p0, 1);
      chk("bounce_state", state_o, 2);
      chk("bounce_valB", valB, 1);
      btn = 1'b0; tick(10);
      chk("release_press", npress - p0, 1);

      // asynchronous reset mid-cycle
      sw = 3'b101;
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      chk("arst_valA", valA, 0);
      chk("arst_valB", valB, 0);
      chk("arst_valid", vals_valid, 0);
      chk("arst_state", state_o, 0);
      tick(2);
      rst_n = 1'b1;

      // reset during B debounce; button held through release
      do_press(3'd4, "r5A");
      chk("r5A_state", state_o, 1);
      sw = 3'd6; tick(3);
      btn = 1'b1; tick(3);
      #2 rst_n = 1'b0; #1;
      chk("r5_state", state_o, 0);
      chk("r5_valA", valA, 0);
      @(negedge clk); rst_n = 1'b1;
      wait_press("r5");
      @(negedge clk); btn = 1'b0;
      @(negedge clk);
      chk("r5_loadA", valA, 6);
      chk("r5_stateB", state_o, 1);

      // dwell in SHOW
      do_press(3'd1, "t6");
      chk("t6_valid", vals_valid, 1);
`ifdef OPERAND_CAPTURE_TIMEOUT_EN
      tick(7);
      chk("t6_pre_valid", vals_valid, 1);
      tick(1);
      chk("t6_state", state_o, 0);
      chk("t6_valid_off", vals_valid, 0);
      chk("t6_valA", valA, 6);
      chk("t6_valB", valB, 1);
`else
      tick(100);
      chk("t6_hold_valid", vals_valid, 1);
      chk("t6_hold_state", state_o, 2);
`endif

      // random button/switch activity against the reference
      for (int i = 0; i < 80; i++) begin
         sw  = W'($urandom);
         btn = 1'($urandom);
         tick($urandom_range(1, 8));
      end
      btn = 1'b0;
      tick(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
